// File: rtl/can_pkg.sv
// Shared CAN decoder definitions: tail-sequencer state codes, bus levels, default field lengths.
package can_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CRC_DEL  = 3'd1,
    ACK_SLOT = 3'd2,
    ACK_DEL  = 3'd3,
    EOF      = 3'd4,
    IFS      = 3'd5,
    ERR_WAIT = 3'd6
  } state_e;

  localparam logic DOMINANT  = 1'b0;
  localparam logic RECESSIVE = 1'b1;

  localparam int EOF_LEN_DEF     = 7;
  localparam int IFS_LEN_DEF     = 3;
  localparam int RECOVER_LEN_DEF = 11;
  localparam int CNT_W_DEF       = 4;

endpackage

// File: rtl/can_tail_sequencer.sv
// CAN frame tail sequencer: CRC delimiter, ACK slot/delimiter, EOF and intermission,
// with error/overload flagging and a recessive-run recovery wait after any fault.
module can_tail_sequencer
  import can_pkg::*;
#(
  parameter int EOF_LEN     = EOF_LEN_DEF,
  parameter int IFS_LEN     = IFS_LEN_DEF,
  parameter int RECOVER_LEN = RECOVER_LEN_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       SP,
  input  logic       RX,
  input  logic       crc_done,
  input  logic       abort,
  output logic       eof_flag,
  output logic       form_error,
  output logic       ack_error,
  output logic       eof_error,
  output logic       overload,
  output logic       frame_ok,
  output logic       bus_idle,
  output logic [2:0] state
);

  // One extra bit so the incremented count (bit index n) never overflows in comparisons.
  localparam logic [CNT_W:0] ONE_N = (CNT_W + 1)'(1);
  localparam logic [CNT_W:0] EOF_N = (CNT_W + 1)'(EOF_LEN);
  localparam logic [CNT_W:0] IFS_N = (CNT_W + 1)'(IFS_LEN);
  localparam logic [CNT_W:0] REC_N = (CNT_W + 1)'(RECOVER_LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W:0]   bit_n;
  logic             eof_flag_q, eof_flag_d;
  logic             form_error_q, form_error_d;
  logic             ack_error_q, ack_error_d;
  logic             eof_error_q, eof_error_d;
  logic             overload_q, overload_d;
  logic             frame_ok_q, frame_ok_d;

  assign bit_n = {1'b0, bit_cnt_q} + ONE_N;

  // Next state, bit counter and pulse requests; abort overrides everything at the end.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    eof_flag_d   = 1'b0;
    form_error_d = 1'b0;
    ack_error_d  = 1'b0;
    eof_error_d  = 1'b0;
    overload_d   = 1'b0;
    frame_ok_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // A coincident SP is the last CRC bit, so it is deliberately not evaluated here.
        if (crc_done) begin
          state_d   = CRC_DEL;
          bit_cnt_d = '0;
        end
      end
      CRC_DEL: begin
        if (SP) begin
          bit_cnt_d = '0;
          if (RX == RECESSIVE) begin
            state_d = ACK_SLOT;
          end else begin
            state_d      = ERR_WAIT;
            form_error_d = 1'b1;
          end
        end
      end
      ACK_SLOT: begin
        if (SP) begin
          bit_cnt_d = '0;
          if (RX == DOMINANT) begin
            state_d = ACK_DEL;
          end else begin
            state_d     = ERR_WAIT;
            ack_error_d = 1'b1;
          end
        end
      end
      ACK_DEL: begin
        if (SP) begin
          bit_cnt_d = '0;
          if (RX == RECESSIVE) begin
            state_d    = EOF;
            eof_flag_d = 1'b1;
          end else begin
            state_d      = ERR_WAIT;
            form_error_d = 1'b1;
          end
        end
      end
      EOF: begin
        if (SP) begin
          if (bit_n < EOF_N) begin
            if (RX == DOMINANT) begin
              state_d     = ERR_WAIT;
              bit_cnt_d   = '0;
              eof_error_d = 1'b1;
            end else begin
              bit_cnt_d = bit_n[CNT_W-1:0];
            end
          end else begin
            // Dominant in the last EOF bit still completes the frame but signals overload.
            frame_ok_d = 1'b1;
            bit_cnt_d  = '0;
            if (RX == RECESSIVE) begin
              state_d = IFS;
            end else begin
              state_d    = ERR_WAIT;
              overload_d = 1'b1;
            end
          end
        end
      end
      IFS: begin
        if (SP) begin
          if (bit_n >= IFS_N) begin
            // Dominant in the last intermission bit is a new SOF, so simply release to IDLE.
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else if (RX == DOMINANT) begin
            state_d    = ERR_WAIT;
            bit_cnt_d  = '0;
            overload_d = 1'b1;
          end else begin
            bit_cnt_d = bit_n[CNT_W-1:0];
          end
        end
      end
      ERR_WAIT: begin
        if (SP) begin
          if (RX == DOMINANT) begin
            bit_cnt_d = '0;
          end else if (bit_n >= REC_N) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_n[CNT_W-1:0];
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
    if (abort) begin
      state_d      = IDLE;
      bit_cnt_d    = '0;
      eof_flag_d   = 1'b0;
      form_error_d = 1'b0;
      ack_error_d  = 1'b0;
      eof_error_d  = 1'b0;
      overload_d   = 1'b0;
      frame_ok_d   = 1'b0;
    end
  end

  // State, counter and one-clock pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      eof_flag_q   <= 1'b0;
      form_error_q <= 1'b0;
      ack_error_q  <= 1'b0;
      eof_error_q  <= 1'b0;
      overload_q   <= 1'b0;
      frame_ok_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      eof_flag_q   <= eof_flag_d;
      form_error_q <= form_error_d;
      ack_error_q  <= ack_error_d;
      eof_error_q  <= eof_error_d;
      overload_q   <= overload_d;
      frame_ok_q   <= frame_ok_d;
    end
  end

  assign eof_flag   = eof_flag_q;
  assign form_error = form_error_q;
  assign ack_error  = ack_error_q;
  assign eof_error  = eof_error_q;
  assign overload   = overload_q;
  assign frame_ok   = frame_ok_q;
  assign bus_idle   = (state_q == IDLE);
  assign state      = state_q;

endmodule

// File: tb/tb_can_tail_sequencer.sv
// Directed bench for can_tail_sequencer: expected pulses/state queued per stimulus step,
// popped and compared one time unit after the clock edge that produces them.
module tb_can_tail_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       SP = 1'b0;
  logic       RX = 1'b1;
  logic       crc_done = 1'b0;
  logic       abort = 1'b0;
  logic       eof_flag, form_error, ack_error, eof_error, overload, frame_ok, bus_idle;
  logic [2:0] state;

  localparam logic [5:0] P_NONE = 6'b000000;
  localparam logic [5:0] P_EOFF = 6'b100000;
  localparam logic [5:0] P_FORM = 6'b010000;
  localparam logic [5:0] P_ACK  = 6'b001000;
  localparam logic [5:0] P_EOFE = 6'b000100;
  localparam logic [5:0] P_OVL  = 6'b000010;
  localparam logic [5:0] P_OK   = 6'b000001;

  int errs = 0;
  int checks = 0;
  logic [8:0] sb[$];

  can_tail_sequencer dut (
    .clock(clock), .reset(reset), .SP(SP), .RX(RX), .crc_done(crc_done), .abort(abort),
    .eof_flag(eof_flag), .form_error(form_error), .ack_error(ack_error),
    .eof_error(eof_error), .overload(overload), .frame_ok(frame_ok),
    .bus_idle(bus_idle), .state(state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag);
    logic [8:0] e;
    logic [5:0] pulses;
    checks++;
    assert (sb.size() != 0) else begin
      errs++;
      $error("FAIL %s scoreboard empty", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      pulses = {eof_flag, form_error, ack_error, eof_error, overload, frame_ok};
      checks++;
      assert (pulses === e[8:3]) else begin
        errs++;
        $error("FAIL %s pulses got=%b exp=%b", tag, pulses, e[8:3]);
      end
      checks++;
      assert (state === e[2:0]) else begin
        errs++;
        $error("FAIL %s state got=%0d exp=%0d", tag, state, e[2:0]);
      end
      checks++;
      assert (bus_idle === (e[2:0] == 3'd0)) else begin
        errs++;
        $error("FAIL %s bus_idle got=%b exp=%b", tag, bus_idle, (e[2:0] == 3'd0));
      end
    end
  endtask

  // One clock of stimulus, then the check of what that edge produced.
  task automatic step(input logic sp, input logic rx, input logic crc, input logic ab,
                      input logic [5:0] ep, input logic [2:0] es, input string tag);
    @(negedge clock);
    SP = sp; RX = rx; crc_done = crc; abort = ab;
    sb.push_back({ep, es});
    @(posedge clock);
    #1;
    SP = 1'b0; crc_done = 1'b0; abort = 1'b0; RX = 1'b1;
    check(tag);
  endtask

  // A sampled bit followed by an idle clock in which every pulse must be gone.
  task automatic bit_in(input logic rx, input logic [5:0] ep, input logic [2:0] es,
                        input string tag);
    step(1'b1, rx, 1'b0, 1'b0, ep, es, tag);
    step(1'b0, ~rx, 1'b0, 1'b0, P_NONE, es, {tag, "_gap"});
  endtask

  task automatic goto_eof();
    step(1'b0, 1'b1, 1'b1, 1'b0, P_NONE, 3'd1, "crc_done");
    bit_in(1'b1, P_NONE, 3'd2, "crc_del");
    bit_in(1'b0, P_NONE, 3'd3, "ack_slot");
    bit_in(1'b1, P_EOFF, 3'd4, "ack_del");
  endtask

  task automatic recover(input int ones);
    for (int i = 1; i < ones; i++) bit_in(1'b1, P_NONE, 3'd6, "recov");
    bit_in(1'b1, P_NONE, 3'd0, "recov_done");
  endtask

  initial begin
    // Reset state
    #2;
    sb.push_back({P_NONE, 3'd0});
    check("reset");
    @(negedge clock);
    reset = 1'b0;

    // Good tail
    goto_eof();
    for (int i = 1; i < 7; i++) bit_in(1'b1, P_NONE, 3'd4, "eof_bit");
    bit_in(1'b1, P_OK, 3'd5, "eof_last");
    bit_in(1'b1, P_NONE, 3'd5, "ifs1");
    bit_in(1'b1, P_NONE, 3'd5, "ifs2");
    bit_in(1'b1, P_NONE, 3'd0, "ifs3");

    // SP alone in IDLE does nothing
    bit_in(1'b0, P_NONE, 3'd0, "idle_sp");

    // EOF bit 4 dominant
    goto_eof();
    for (int i = 1; i < 4; i++) bit_in(1'b1, P_NONE, 3'd4, "eof_bit");
    bit_in(1'b0, P_EOFE, 3'd6, "eof4_dom");
    recover(11);

    // EOF bit 7 dominant: frame_ok with overload
    goto_eof();
    step(1'b0, 1'b1, 1'b1, 1'b0, P_NONE, 3'd4, "crc_in_eof");
    for (int i = 1; i < 7; i++) bit_in(1'b1, P_NONE, 3'd4, "eof_bit");
    bit_in(1'b0, P_OK | P_OVL, 3'd6, "eof7_dom");
    recover(11);

    // Dominant in intermission bit 2 -> overload; bit 3 dominant -> SOF
    goto_eof();
    for (int i = 1; i < 8; i++) bit_in(1'b1, (i == 7) ? P_OK : P_NONE, (i == 7) ? 3'd5 : 3'd4, "eof_bit");
    bit_in(1'b1, P_NONE, 3'd5, "ifs1");
    bit_in(1'b0, P_OVL, 3'd6, "ifs2_dom");
    recover(11);
    goto_eof();
    for (int i = 1; i < 8; i++) bit_in(1'b1, (i == 7) ? P_OK : P_NONE, (i == 7) ? 3'd5 : 3'd4, "eof_bit");
    bit_in(1'b1, P_NONE, 3'd5, "ifs1");
    bit_in(1'b1, P_NONE, 3'd5, "ifs2");
    bit_in(1'b0, P_NONE, 3'd0, "ifs3_sof");

    // CRC delimiter dominant
    step(1'b0, 1'b1, 1'b1, 1'b0, P_NONE, 3'd1, "crc_done");
    bit_in(1'b0, P_FORM, 3'd6, "crc_del_dom");
    recover(11);

    // ACK slot recessive
    step(1'b0, 1'b1, 1'b1, 1'b0, P_NONE, 3'd1, "crc_done");
    bit_in(1'b1, P_NONE, 3'd2, "crc_del");
    bit_in(1'b1, P_ACK, 3'd6, "ack_rec");
    // Recovery restart after 10 recessive bits
    for (int i = 0; i < 10; i++) bit_in(1'b1, P_NONE, 3'd6, "recov10");
    bit_in(1'b0, P_NONE, 3'd6, "recov_dom");
    recover(11);

    // ACK delimiter dominant
    step(1'b0, 1'b1, 1'b1, 1'b0, P_NONE, 3'd1, "crc_done");
    bit_in(1'b1, P_NONE, 3'd2, "crc_del");
    bit_in(1'b0, P_NONE, 3'd3, "ack_slot");
    bit_in(1'b0, P_FORM, 3'd6, "ack_del_dom");
    recover(11);

    // crc_done with SP in the same cycle: SP ignored
    step(1'b1, 1'b0, 1'b1, 1'b0, P_NONE, 3'd1, "crc_with_sp");
    bit_in(1'b1, P_NONE, 3'd2, "crc_del");
    step(1'b1, 1'b1, 1'b0, 1'b1, P_NONE, 3'd0, "abort_ack");

    // abort during EOF, with a would-be eof_error bit in the same cycle
    goto_eof();
    bit_in(1'b1, P_NONE, 3'd4, "eof_bit");
    step(1'b1, 1'b0, 1'b0, 1'b1, P_NONE, 3'd0, "abort_eof");
    step(1'b0, 1'b1, 1'b0, 1'b0, P_NONE, 3'd0, "abort_gap");

    // Asynchronous reset mid-EOF
    goto_eof();
    bit_in(1'b1, P_NONE, 3'd4, "eof_bit");
    bit_in(1'b1, P_NONE, 3'd4, "eof_bit");
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    sb.push_back({P_NONE, 3'd0});
    check("async_reset");
    @(negedge clock);
    reset = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0, P_NONE, 3'd1, "post_reset_crc");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
